// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one downstream memory port between the instruction
// fetch requester (read-only) and the load/store requester (read or write).
// One transaction in flight at a time, round-robin on ties, request fields
// captured at grant so requesters may change them without disturbing the bus.
//
// Handshake summary:
//   Requester side is hold-until-done: req stays high (fields stable) until
//   the matching done pulse; done is a single-cycle pulse with rdata valid in
//   the same cycle and held afterwards. Downstream request side is
//   valid/ready: mem_req_valid and all mem_req_* fields stay stable while
//   valid is high, and the request is consumed in the cycle valid && ready.
//   Downstream response is a one-cycle mem_resp_valid strobe that is only
//   honoured while a response is outstanding.
module mem_bus_arbiter (
  input  logic        ACLK,
  input  logic        ARESETn,
  // instruction fetch requester
  input  logic        ifu_req,
  input  logic [63:0] ifu_addr,
  output logic        ifu_done,
  output logic [63:0] ifu_rdata,
  // load/store requester
  input  logic        lsu_req,
  input  logic        lsu_write,
  input  logic [63:0] lsu_addr,
  input  logic [63:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_done,
  output logic [63:0] lsu_rdata,
  // downstream memory port
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_write,
  output logic [63:0] mem_req_addr,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Requester identity encoding shared by the owner and last-grant registers.
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t      state_q;
  logic        owner_q;
  logic        last_q;

  logic        mem_req_valid_q;
  logic        mem_req_write_q;
  logic [63:0] mem_req_addr_q;
  logic [63:0] mem_req_wdata_q;
  logic [7:0]  mem_req_wmask_q;

  logic        ifu_done_q;
  logic [63:0] ifu_rdata_q;
  logic        lsu_done_q;
  logic [63:0] lsu_rdata_q;

  // Grant decision for the current IDLE sample.
  logic        grant_any_d;
  logic        grant_lsu_d;
  logic        grant_write_d;
  logic [63:0] grant_addr_d;
  logic [63:0] grant_wdata_d;
  logic [7:0]  grant_wmask_d;

  // Round-robin arbitration: a lone requester always wins; on a tie the
  // requester that was not granted last time wins.
  always_comb begin
    grant_any_d   = ifu_req | lsu_req;
    grant_lsu_d   = lsu_req & (~ifu_req | (last_q == OWN_IFU));
    grant_write_d = 1'b0;
    grant_addr_d  = ifu_addr;
    grant_wdata_d = 64'd0;
    grant_wmask_d = 8'd0;
    if (grant_lsu_d) begin
      grant_write_d = lsu_write;
      grant_addr_d  = lsu_addr;
      grant_wdata_d = lsu_wdata;
      // byte enables are meaningful only for writes
      grant_wmask_d = lsu_write ? lsu_wmask : 8'd0;
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q         <= ST_IDLE;
      owner_q         <= OWN_IFU;
      last_q          <= OWN_IFU;
      mem_req_valid_q <= 1'b0;
      mem_req_write_q <= 1'b0;
      mem_req_addr_q  <= 64'd0;
      mem_req_wdata_q <= 64'd0;
      mem_req_wmask_q <= 8'd0;
      ifu_done_q      <= 1'b0;
      ifu_rdata_q     <= 64'd0;
      lsu_done_q      <= 1'b0;
      lsu_rdata_q     <= 64'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_any_d) begin
            owner_q         <= grant_lsu_d;
            last_q          <= grant_lsu_d;
            mem_req_valid_q <= 1'b1;
            mem_req_write_q <= grant_write_d;
            mem_req_addr_q  <= grant_addr_d;
            mem_req_wdata_q <= grant_wdata_d;
            mem_req_wmask_q <= grant_wmask_d;
            state_q         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            if (owner_q == OWN_LSU) begin
              lsu_rdata_q <= mem_resp_rdata;
              lsu_done_q  <= 1'b1;
            end else begin
              ifu_rdata_q <= mem_resp_rdata;
              ifu_done_q  <= 1'b1;
            end
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // done pulse lasts this one cycle; requests are not sampled here
          ifu_done_q <= 1'b0;
          lsu_done_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_write = mem_req_write_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_wdata = mem_req_wdata_q;
  assign mem_req_wmask = mem_req_wmask_q;
  assign ifu_done      = ifu_done_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_done      = lsu_done_q;
  assign lsu_rdata     = lsu_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single IFU read, stalled LSU write,
// round-robin on ties, field changes after grant, spurious responses,
// reset mid-transaction and back-to-back requests.
module tb_mem_bus_arbiter;

  logic        ACLK;
  logic        ARESETn;
  logic        ifu_req;
  logic [63:0] ifu_addr;
  logic        ifu_done;
  logic [63:0] ifu_rdata;
  logic        lsu_req;
  logic        lsu_write;
  logic [63:0] lsu_addr;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_done;
  logic [63:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter dut (
    .ACLK           (ACLK),
    .ARESETn        (ARESETn),
    .ifu_req        (ifu_req),
    .ifu_addr       (ifu_addr),
    .ifu_done       (ifu_done),
    .ifu_rdata      (ifu_rdata),
    .lsu_req        (lsu_req),
    .lsu_write      (lsu_write),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_done       (lsu_done),
    .lsu_rdata      (lsu_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  // clock
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // overall time limit
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

  // advance one cycle and settle just past the edge
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // From IDLE with a request already presented: sample, accept at once,
  // respond at once, check the done cycle, then step to done+1.
  task automatic run_txn(input string tag, input logic [63:0] exp_addr,
                         input logic exp_lsu, input logic [63:0] data);
    tick();
    check({tag, "_valid"}, mem_req_valid, 1'b1);
    check({tag, "_addr"}, mem_req_addr, exp_addr);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = data;
    tick();
    mem_resp_valid = 1'b0;
    check({tag, "_ifu_done"}, ifu_done, !exp_lsu);
    check({tag, "_lsu_done"}, lsu_done, exp_lsu);
    if (exp_lsu) check({tag, "_lsu_rdata"}, lsu_rdata, data);
    else         check({tag, "_ifu_rdata"}, ifu_rdata, data);
    tick();
    check({tag, "_done_clear"}, {62'd0, ifu_done, lsu_done}, 64'd0);
    check({tag, "_idle_valid"}, mem_req_valid, 1'b0);
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    tick();
    tick();
    ARESETn = 1'b1;
  endtask

  initial begin
    ARESETn        = 1'b0;
    ifu_req        = 1'b0;
    ifu_addr       = 64'd0;
    lsu_req        = 1'b0;
    lsu_write      = 1'b0;
    lsu_addr       = 64'd0;
    lsu_wdata      = 64'd0;
    lsu_wmask      = 8'd0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 64'd0;
    do_reset();

    // reset state
    check("rst_valid", mem_req_valid, 1'b0);
    check("rst_addr", mem_req_addr, 64'd0);
    check("rst_dones", {62'd0, ifu_done, lsu_done}, 64'd0);
    check("rst_ifu_rdata", ifu_rdata, 64'd0);
    check("rst_lsu_rdata", lsu_rdata, 64'd0);

    // IFU alone
    ifu_req  = 1'b1;
    ifu_addr = 64'h0000_0000_8000_0000;
    tick();
    check("ifu_valid", mem_req_valid, 1'b1);
    check("ifu_addr", mem_req_addr, 64'h0000_0000_8000_0000);
    check("ifu_write", mem_req_write, 1'b0);
    check("ifu_wmask", mem_req_wmask, 8'h00);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("ifu_accept_valid", mem_req_valid, 1'b0);
    check("ifu_early_done", ifu_done, 1'b0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hDEAD_BEEF_0000_0013;
    tick();
    mem_resp_valid = 1'b0;
    ifu_req        = 1'b0;
    check("ifu_done", ifu_done, 1'b1);
    check("ifu_rdata", ifu_rdata, 64'hDEAD_BEEF_0000_0013);
    check("ifu_lsu_done", lsu_done, 1'b0);
    tick();
    check("ifu_done_pulse", ifu_done, 1'b0);
    check("ifu_rdata_hold", ifu_rdata, 64'hDEAD_BEEF_0000_0013);

    // LSU write with ready delayed 3 cycles
    lsu_req   = 1'b1;
    lsu_write = 1'b1;
    lsu_addr  = 64'h0000_0000_8000_1000;
    lsu_wdata = 64'h1122_3344_5566_7788;
    lsu_wmask = 8'h0F;
    tick();
    check("wr_write", mem_req_write, 1'b1);
    check("wr_wdata", mem_req_wdata, 64'h1122_3344_5566_7788);
    check("wr_wmask", mem_req_wmask, 8'h0F);
    for (int i = 0; i < 4; i++) begin
      check("wr_valid_held", mem_req_valid, 1'b1);
      check("wr_addr_held", mem_req_addr, 64'h0000_0000_8000_1000);
      if (i < 3) tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("wr_valid_drop", mem_req_valid, 1'b0);
    check("wr_no_done_yet", lsu_done, 1'b0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h0000_0000_0000_A5A5;
    tick();
    mem_resp_valid = 1'b0;
    lsu_req        = 1'b0;
    lsu_write      = 1'b0;
    check("wr_lsu_done", lsu_done, 1'b1);
    check("wr_ifu_done", ifu_done, 1'b0);
    check("wr_lsu_rdata", lsu_rdata, 64'h0000_0000_0000_A5A5);
    tick();
    check("wr_done_pulse", lsu_done, 1'b0);

    // simultaneous requests straight after reset: LSU, IFU, LSU, IFU
    do_reset();
    ifu_req  = 1'b1;
    ifu_addr = 64'h0000_0000_0000_1000;
    lsu_req  = 1'b1;
    lsu_addr = 64'h0000_0000_0000_2000;
    run_txn("rr0_lsu", 64'h0000_0000_0000_2000, 1'b1, 64'h0000_0000_0000_0A01);
    run_txn("rr1_ifu", 64'h0000_0000_0000_1000, 1'b0, 64'h0000_0000_0000_0B02);
    run_txn("rr2_lsu", 64'h0000_0000_0000_2000, 1'b1, 64'h0000_0000_0000_0C03);
    run_txn("rr3_ifu", 64'h0000_0000_0000_1000, 1'b0, 64'h0000_0000_0000_0D04);
    ifu_req = 1'b0;
    lsu_req = 1'b0;

    // fields changed during ISSUE; req dropped mid-WAIT
    lsu_req  = 1'b1;
    lsu_addr = 64'h0000_0000_0000_0100;
    tick();
    check("chg_addr", mem_req_addr, 64'h0000_0000_0000_0100);
    check("chg_rd_wmask", mem_req_wmask, 8'h00);
    lsu_addr = 64'h0000_0000_0000_0200;
    tick();
    check("chg_addr_stable", mem_req_addr, 64'h0000_0000_0000_0100);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    lsu_req       = 1'b0;
    tick();
    check("drop_wait_no_done", lsu_done, 1'b0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h0000_0000_0000_0E05;
    tick();
    mem_resp_valid = 1'b0;
    check("drop_done", lsu_done, 1'b1);
    check("drop_rdata", lsu_rdata, 64'h0000_0000_0000_0E05);
    tick();

    // spurious response while idle
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem_resp_valid = 1'b0;
    check("spur_dones", {62'd0, ifu_done, lsu_done}, 64'd0);
    check("spur_lsu_rdata", lsu_rdata, 64'h0000_0000_0000_0E05);
    check("spur_ifu_rdata", ifu_rdata, 64'h0000_0000_0000_0D04);
    check("spur_valid", mem_req_valid, 1'b0);

    // reset asserted in WAIT
    ifu_req  = 1'b1;
    ifu_addr = 64'h0000_0000_0000_0040;
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    ARESETn = 1'b0;
    ifu_req = 1'b0;
    #1;
    check("arst_addr", mem_req_addr, 64'd0);
    check("arst_ifu_rdata", ifu_rdata, 64'd0);
    check("arst_lsu_rdata", lsu_rdata, 64'd0);
    check("arst_valid", mem_req_valid, 1'b0);
    tick();
    ARESETn        = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h0000_0000_0000_BAD0;
    tick();
    mem_resp_valid = 1'b0;
    check("arst_late_resp_done", {62'd0, ifu_done, lsu_done}, 64'd0);
    check("arst_late_resp_rdata", ifu_rdata, 64'd0);

    // new IFU request after reset, req held through done: second
    // transaction issues at done+2
    ifu_req  = 1'b1;
    ifu_addr = 64'h0000_0000_8000_0040;
    run_txn("post_rst", 64'h0000_0000_8000_0040, 1'b0, 64'h0000_0000_1234_5678);
    run_txn("held_req", 64'h0000_0000_8000_0040, 1'b0, 64'h0000_0000_8765_4321);
    ifu_req = 1'b0;
    tick();
    check("final_idle", mem_req_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
